mac_tile_sequencer: RTL and testbench
=====================================

# mac_tile_sequencer

Control sequencer for the 5-lane pipelined MAC array. It accepts a job request with runtime weight and input counts, then paces the weight stream and input stream into the array's buffers. It steps the MAC lanes across the input columns, waits out the MAC pipeline, and presents a result-valid handshake with a latched overflow flag. It owns no datapath arithmetic; it drives the strobes, addresses and enables of the matmul datapath.

## Interface
- N, 5, max weight words per job (buffer depth)
- T, 10, max input columns per job
- MAC_LAT, 2, MAC pipeline latency in cycles (≥1)

- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- start_i  in  1  job request, honoured only in IDLE
- abort_i  in  1  cancel current job
- reuse_w_i  in  1  skip weight load (see Configuration)
- cfg_n_i  in  4  weight words this job, legal 1..N, latched at start
- cfg_t_i  in  4  input columns this job, legal 1..T, latched at start
- w_valid_i / w_ready_o  in/out  1  weight stream handshake
- x_valid_i / x_ready_o  in/out  1  input stream handshake
- w_we_o, w_addr_o  out  1, 4  weight buffer write strobe/address
- x_we_o, x_addr_o  out  1, 4  input buffer write strobe/address
- mac_clr_o  out  1  clear MAC accumulators
- mac_en_o, mac_sel_o  out  1, 4  MAC step enable, column index
- ov_i  in  1  datapath overflow (any lane upper byte nonzero)
- res_valid_o / res_ready_i  out/in  1  result handshake
- ov_o  out  1  overflow latched with result
- busy_o, done_o, err_o  out  1  status; done_o/err_o single-cycle pulses

## Operation
- States: IDLE, LOAD_W, LOAD_X, CLEAR, COMPUTE, DRAIN, OUT.
- IDLE: on start_i, check the config. If cfg_n_i or cfg_t_i is 0 or exceeds N/T, pulse err_o and stay in IDLE. Otherwise latch the config and go to LOAD_W.
- LOAD_W: w_ready_o=1. Each beat (w_valid_i&w_ready_o) asserts w_we_o with w_addr_o=beat index 0..cfg_n-1. Go to LOAD_X after beat cfg_n-1.
- LOAD_X: same rules on the x_* signals for cfg_t beats. Then go to CLEAR.
- CLEAR: one cycle with mac_clr_o=1, then COMPUTE.
- COMPUTE: cfg_t consecutive cycles with mac_en_o=1 and mac_sel_o=0,1,..,cfg_t-1. Then DRAIN.
- DRAIN: MAC_LAT cycles, all strobes low. On the last DRAIN cycle, sample ov_i into ov_o. Then OUT.
- OUT: res_valid_o=1 and held until res_ready_i. On the accepting edge: pulse done_o, deassert res_valid_o, go to IDLE.
- busy_o=1 in every state except IDLE.
- Strobes (w_we_o, x_we_o, mac_*) are active only in their own state. Addresses hold their last value otherwise.
- Valid without ready, or ready without valid, does nothing.
- abort_i in any non-IDLE state: go to IDLE on the next edge. No done_o, res_valid_o drops, the weights-valid flag clears. abort_i wins over a beat or a result accept on the same edge.
- abort_i and start_i together in IDLE: the start is ignored.
- start_i outside IDLE is ignored.

## Timing
- Reset: state IDLE; every output 0, including addresses, ov_o and the weights-valid flag.
- Streams without stalls, start sampled at edge 0:
  - LOAD_W beats on edges 1..cfg_n.
  - LOAD_X beats on edges cfg_n+1..cfg_n+cfg_t.
  - mac_clr_o is high in cycle cfg_n+cfg_t+1.
  - res_valid_o first rises after edge 1+cfg_n+2·cfg_t+MAC_LAT+1.
- Stall cycles (valid low) add one cycle each. Counters never advance without a beat.
- All outputs are registered or decoded purely from state and counters. The only combinational input-to-output path allowed is none.

## Configuration
- MAC_SEQ_WEIGHT_REUSE_EN defined:
  - A weights-valid flag is set when LOAD_W completes. It is cleared by RST or abort_i.
  - If reuse_w_i=1 at an accepted start and the flag is set, the sequencer skips LOAD_W, keeps the previous weights, and goes straight to LOAD_X.
  - In that case cfg_n_i is not checked. The previous cfg_n is retained.
- Macro undefined: reuse_w_i is ignored and LOAD_W always runs. Port list is unchanged.

## Test plan
- cfg_n=5, cfg_t=10, MAC_LAT=2, no stalls:
  - 5 w_we_o pulses with addr 0..4, then 10 x_we_o pulses with addr 0..9.
  - mac_clr_o is one cycle.
  - mac_sel_o steps 0..9.
  - res_valid_o after edge 29, and done_o follows the accept.
- start with cfg_t=0, and separately cfg_n=6 -> one-cycle err_o each time, busy_o stays 0, no strobes.
- w_valid_i toggling 1,0,1,0 during LOAD_W with cfg_n=3 -> exactly 3 writes at addr 0,1,2, and LOAD_X entered after the third beat.
- res_ready_i held low for 7 cycles in OUT -> res_valid_o and ov_o stable throughout. ov_i=1 at the last DRAIN cycle gives ov_o=1.
- abort_i in COMPUTE at mac_sel_o=4 -> IDLE next cycle, mac_en_o low, no res_valid_o, no done_o. A new start works normally.
- With MAC_SEQ_WEIGHT_REUSE_EN:
  - A second job with reuse_w_i=1 -> no w_ready_o, and LOAD_X starts at edge 1.
  - After an abort, the same request performs a full LOAD_W.

Source files
------------

// File: rtl/mac_tile_sequencer.sv
// Control sequencer for the 5-lane MAC array: loads weights and inputs, steps the columns, drains and returns the result.
// Define MAC_SEQ_WEIGHT_REUSE_EN to let a job skip LOAD_W and reuse the previously loaded weights.
module mac_tile_sequencer #(
  parameter int unsigned N       = 5,
  parameter int unsigned T       = 10,
  parameter int unsigned MAC_LAT = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start_i,
  input  logic       abort_i,
  input  logic       reuse_w_i,
  input  logic [3:0] cfg_n_i,
  input  logic [3:0] cfg_t_i,
  input  logic       w_valid_i,
  output logic       w_ready_o,
  input  logic       x_valid_i,
  output logic       x_ready_o,
  output logic       w_we_o,
  output logic [3:0] w_addr_o,
  output logic       x_we_o,
  output logic [3:0] x_addr_o,
  output logic       mac_clr_o,
  output logic       mac_en_o,
  output logic [3:0] mac_sel_o,
  input  logic       ov_i,
  output logic       res_valid_o,
  input  logic       res_ready_i,
  output logic       ov_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o
);

  localparam logic [3:0] LP_N      = 4'(N);
  localparam logic [3:0] LP_T      = 4'(T);
  localparam logic [3:0] LP_LAT_M1 = 4'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_W, S_LOAD_X, S_CLEAR, S_COMPUTE, S_DRAIN, S_OUT
  } state_t;

  state_t     r_state, w_next;
  logic [3:0] r_cfg_n, r_cfg_t, r_cnt, r_sel, r_w_addr, r_x_addr;
  logic       r_w_we, r_x_we, r_res_valid, r_ov, r_done, r_err;
  logic       w_reuse, w_cfg_ok, w_wbeat, w_xbeat, w_accept, w_cnt_en;

`ifdef MAC_SEQ_WEIGHT_REUSE_EN
  logic r_wvalid;

  // Flag survives across jobs; only a completed LOAD_W sets it, any abort drops it.
  always_ff @(posedge CLK) begin
    if (RST || abort_i) r_wvalid <= 1'b0;
    else if (r_state == S_LOAD_W && w_next == S_LOAD_X) r_wvalid <= 1'b1;
  end

  assign w_reuse = reuse_w_i & r_wvalid;
`else
  logic w_unused_reuse;
  assign w_unused_reuse = reuse_w_i;
  assign w_reuse        = 1'b0;
`endif

  assign w_cfg_ok = (w_reuse || (cfg_n_i != '0 && cfg_n_i <= LP_N)) &&
                    (cfg_t_i != '0 && cfg_t_i <= LP_T);
  assign w_wbeat  = w_valid_i & (r_state == S_LOAD_W);
  assign w_xbeat  = x_valid_i & (r_state == S_LOAD_X);
  assign w_accept = r_res_valid & res_ready_i;
  assign w_cnt_en = w_wbeat | w_xbeat | (r_state == S_DRAIN);

  always_ff @(posedge CLK) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start_i && !abort_i && w_cfg_ok) w_next = w_reuse ? S_LOAD_X : S_LOAD_W;
      S_LOAD_W:  if (w_wbeat && r_cnt == r_cfg_n - 4'd1) w_next = S_LOAD_X;
      S_LOAD_X:  if (w_xbeat && r_cnt == r_cfg_t - 4'd1) w_next = S_CLEAR;
      S_CLEAR:   w_next = S_COMPUTE;
      S_COMPUTE: if (r_sel == r_cfg_t - 4'd1) w_next = S_DRAIN;
      S_DRAIN:   if (r_cnt == LP_LAT_M1) w_next = S_OUT;
      S_OUT:     if (w_accept) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (abort_i && r_state != S_IDLE) w_next = S_IDLE;
  end

  always_comb begin
    w_ready_o = (r_state == S_LOAD_W);
    x_ready_o = (r_state == S_LOAD_X);
    mac_clr_o = (r_state == S_CLEAR);
    mac_en_o  = (r_state == S_COMPUTE);
    busy_o    = (r_state != S_IDLE);
  end

  // Beat/drain counter restarts on every state change; address and column registers hold between uses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_cfg_n     <= '0;
      r_cfg_t     <= '0;
      r_cnt       <= '0;
      r_sel       <= '0;
      r_w_addr    <= '0;
      r_x_addr    <= '0;
      r_w_we      <= 1'b0;
      r_x_we      <= 1'b0;
      r_res_valid <= 1'b0;
      r_ov        <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_w_we <= w_wbeat & ~abort_i;
      r_x_we <= w_xbeat & ~abort_i;
      if (w_wbeat && !abort_i) r_w_addr <= r_cnt;
      if (w_xbeat && !abort_i) r_x_addr <= r_cnt;

      if (w_next != r_state) r_cnt <= '0;
      else if (w_cnt_en)     r_cnt <= r_cnt + 4'd1;

      if (!abort_i) begin
        if (r_state == S_CLEAR) r_sel <= '0;
        else if (r_state == S_COMPUTE && w_next == S_COMPUTE) r_sel <= r_sel + 4'd1;
        if (r_state == S_DRAIN && r_cnt == LP_LAT_M1) r_ov <= ov_i;
      end

      r_res_valid <= (r_state == S_OUT) && (w_next == S_OUT);
      r_done      <= w_accept & ~abort_i;
      r_err       <= (r_state == S_IDLE) && start_i && !abort_i && !w_cfg_ok;

      if (r_state == S_IDLE && w_next != S_IDLE) begin
        r_cfg_t <= cfg_t_i;
        if (!w_reuse) r_cfg_n <= cfg_n_i;
      end
    end
  end

  assign w_we_o      = r_w_we;
  assign w_addr_o    = r_w_addr;
  assign x_we_o      = r_x_we;
  assign x_addr_o    = r_x_addr;
  assign mac_sel_o   = r_sel;
  assign res_valid_o = r_res_valid;
  assign ov_o        = r_ov;
  assign done_o      = r_done;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mac_tile_sequencer.sv
// Randomised bench for mac_tile_sequencer: per-job event schedule derived from the stall pattern, checked every cycle.
module tb_mac_tile_sequencer;
  localparam int N       = 5;
  localparam int T       = 10;
  localparam int MAC_LAT = 2;
  localparam int MAXE    = 200;
  localparam int NO_AB   = 1000;

  logic       CLK = 1'b0;
  logic       RST, start_i, abort_i, reuse_w_i, w_valid_i, x_valid_i, ov_i, res_ready_i;
  logic [3:0] cfg_n_i, cfg_t_i;
  logic       w_ready_o, x_ready_o, w_we_o, x_we_o, mac_clr_o, mac_en_o;
  logic       res_valid_o, ov_o, busy_o, done_o, err_o;
  logic [3:0] w_addr_o, x_addr_o, mac_sel_o;

  int checks = 0;
  int errors = 0;
  int job_no = 0;

  logic [3:0] m_waddr = '0, m_xaddr = '0, m_sel = '0;
  logic       m_ov = 1'b0, m_flag = 1'b0;
  int         m_n = 0;

  always #5 CLK = ~CLK;

  mac_tile_sequencer #(.N(N), .T(T), .MAC_LAT(MAC_LAT)) dut (
    .CLK(CLK), .RST(RST), .start_i(start_i), .abort_i(abort_i), .reuse_w_i(reuse_w_i),
    .cfg_n_i(cfg_n_i), .cfg_t_i(cfg_t_i),
    .w_valid_i(w_valid_i), .w_ready_o(w_ready_o), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o),
    .w_we_o(w_we_o), .w_addr_o(w_addr_o), .x_we_o(x_we_o), .x_addr_o(x_addr_o),
    .mac_clr_o(mac_clr_o), .mac_en_o(mac_en_o), .mac_sel_o(mac_sel_o),
    .ov_i(ov_i), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .ov_o(ov_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %08h expected %08h", tag, got, exp);
    end
  endtask

  // {busy, w_ready, x_ready, w_we, w_addr, x_we, x_addr, clr, en, sel, res_valid, ov, done, err}
  function automatic logic [31:0] pack(input logic busy, input logic wr, input logic xr,
      input logic wwe, input logic [3:0] wa, input logic xwe, input logic [3:0] xa,
      input logic clr, input logic en, input logic [3:0] sel,
      input logic rv, input logic ov, input logic done, input logic err);
    return {9'd0, busy, wr, xr, wwe, wa, xwe, xa, clr, en, sel, rv, ov, done, err};
  endfunction

  function automatic logic [31:0] observed();
    return pack(busy_o, w_ready_o, x_ready_o, w_we_o, w_addr_o, x_we_o, x_addr_o,
                mac_clr_o, mac_en_o, mac_sel_o, res_valid_o, ov_o, done_o, err_o);
  endfunction

  function automatic logic [31:0] idle_exp(input logic err);
    return pack(1'b0, 1'b0, 1'b0, 1'b0, m_waddr, 1'b0, m_xaddr, 1'b0, 1'b0, m_sel,
                1'b0, m_ov, 1'b0, err);
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_side();
    w_valid_i   = 1'($urandom_range(1));
    x_valid_i   = 1'($urandom_range(1));
    ov_i        = 1'($urandom_range(1));
    res_ready_i = 1'($urandom_range(1));
    reuse_w_i   = 1'($urandom_range(1));
    cfg_n_i     = 4'($urandom_range(15));
    cfg_t_i     = 4'($urandom_range(15));
  endtask

  task automatic idle(input int cycles, input bit aborts);
    for (int i = 0; i < cycles; i++) begin
      rand_side();
      start_i = 1'b0;
      abort_i = aborts ? 1'($urandom_range(1)) : 1'b0;
      tick();
      if (abort_i) m_flag = 1'b0;
      check("idle", observed(), idle_exp(1'b0));
    end
    abort_i = 1'b0;
  endtask

  task automatic start_with_abort();
    rand_side();
    start_i = 1'b1; abort_i = 1'b1; cfg_n_i = 4'd3; cfg_t_i = 4'd3;
    tick();
    m_flag = 1'b0;
    check("start_abort", observed(), idle_exp(1'b0));
    start_i = 1'b0; abort_i = 1'b0;
  endtask

  // ab_mode: -1 none, -2 random edge, -3 edge 1, >=0 abort while mac_sel shows that column
  task automatic run_job(input int n, input int t, input bit reuse, input int stall_pct,
                         input int dly, input int ab_mode, input bit wtoggle, input bit force_ov,
                         output int rv_edge);
    bit vw [MAXE];
    bit vx [MAXE];
    bit ovp [MAXE];
    bit rdy [MAXE];
    bit stp [MAXE];
    bit reuse_eff, bad, live, wb, xb;
    int nn, ew, ex, o, r, a, ab, fin, cnt, wi, xi;
    logic [31:0] exp;

    job_no++;
    rv_edge = -1;
`ifdef MAC_SEQ_WEIGHT_REUSE_EN
    reuse_eff = reuse && m_flag;
`else
    reuse_eff = 1'b0;
`endif
    bad = (t < 1 || t > T) || (!reuse_eff && (n < 1 || n > N));
    if (bad) begin
      rand_side();
      start_i = 1'b1; abort_i = 1'b0;
      cfg_n_i = 4'(n); cfg_t_i = 4'(t); reuse_w_i = reuse;
      tick();
      check($sformatf("j%0d_err_pulse", job_no), observed(), idle_exp(1'b1));
      rand_side();
      start_i = 1'b0;
      tick();
      check($sformatf("j%0d_err_clear", job_no), observed(), idle_exp(1'b0));
      return;
    end

    nn = reuse_eff ? m_n : n;
    for (int k = 0; k < MAXE; k++) begin
      vw[k]  = (k > 150) ? 1'b1 : wtoggle ? (k % 2 == 1) : ($urandom_range(99) >= stall_pct);
      vx[k]  = (k > 150) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      ovp[k] = force_ov ? 1'b0 : 1'($urandom_range(1));
      stp[k] = ($urandom_range(3) == 0);
      rdy[k] = 1'($urandom_range(1));
    end

    ew = 0;
    cnt = 0;
    if (!reuse_eff)
      for (int k = 1; cnt < nn; k++) if (vw[k]) begin cnt++; ew = k; end
    ex = ew;
    cnt = 0;
    for (int k = ew + 1; cnt < t; k++) if (vx[k]) begin cnt++; ex = k; end
    o = ex + t + MAC_LAT + 1;
    r = o + 1;
    a = r + 1 + dly;
    for (int k = r + 1; k < a; k++) rdy[k] = 1'b0;
    rdy[a] = 1'b1;
    if (force_ov) ovp[o] = 1'b1;

    case (ab_mode)
      -1:      ab = NO_AB;
      -2:      ab = int'($urandom_range(a, 1));
      -3:      ab = 1;
      default: ab = ex + ab_mode + 2;
    endcase
    fin = (a < ab) ? a : ab;

    wi = 0;
    xi = 0;
    for (int k = 0; k <= fin + 1; k++) begin
      w_valid_i = vw[k]; x_valid_i = vx[k]; ov_i = ovp[k]; res_ready_i = rdy[k];
      abort_i = (k == ab);
      if (k == 0) begin
        start_i = 1'b1; cfg_n_i = 4'(n); cfg_t_i = 4'(t); reuse_w_i = reuse;
      end else begin
        start_i   = (k <= fin) ? stp[k] : 1'b0;
        cfg_n_i   = 4'($urandom_range(15));
        cfg_t_i   = 4'($urandom_range(15));
        reuse_w_i = 1'($urandom_range(1));
      end
      tick();

      live = (k < ab);
      wb = live && !reuse_eff && k >= 1 && k <= ew && vw[k];
      xb = live && k > ew && k <= ex && vx[k];
      if (wb) begin m_waddr = 4'(wi); wi++; end
      if (xb) begin m_xaddr = 4'(xi); xi++; end
      if (live && k > ex && k <= ex + t) m_sel = 4'(k - ex - 1);
      if (live && k == o) m_ov = ovp[k];

      if (!live) exp = idle_exp(1'b0);
      else exp = pack(k < a, !reuse_eff && k < ew, k >= ew && k < ex, wb, m_waddr, xb, m_xaddr,
                      k == ex, k > ex && k <= ex + t, m_sel, k >= r && k < a, m_ov, k == a, 1'b0);
      check($sformatf("j%0d_e%0d", job_no, k), observed(), exp);
      if (res_valid_o && rv_edge < 0) rv_edge = k;
    end

    if (ab > a) check($sformatf("j%0d_rv_rise", job_no), rv_edge, r);
    if (!reuse_eff) m_n = n;
    m_flag = (ab > a);
    start_i = 1'b0;
    abort_i = 1'b0;
  endtask

  initial begin
    int rv;
    int n, t;

    RST = 1'b1;
    rand_side();
    start_i = 1'b1; abort_i = 1'b0; cfg_n_i = 4'd2; cfg_t_i = 4'd2;
    tick();
    check("reset0", observed(), pack(0,0,0,0,4'd0,0,4'd0,0,0,4'd0,0,0,0,0));
    tick();
    check("reset1", observed(), pack(0,0,0,0,4'd0,0,4'd0,0,0,4'd0,0,0,0,0));
    RST = 1'b0;
    start_i = 1'b0;
    idle(2, 1'b0);

    run_job(5, 10, 1'b0, 0, 7, -1, 1'b0, 1'b1, rv);
    check("rv_edge_full", rv, 29);
    idle(1, 1'b0);
    run_job(5, 0, 1'b0, 0, 0, -1, 1'b0, 1'b0, rv);
    run_job(6, 4, 1'b0, 0, 0, -1, 1'b0, 1'b0, rv);
    run_job(3, int'($urandom_range(T, 1)), 1'b0, 0, 1, -1, 1'b1, 1'b0, rv);
    run_job(5, 8, 1'b0, 0, 1, 4, 1'b0, 1'b0, rv);
    run_job(5, 6, 1'b0, 0, 0, -1, 1'b0, 1'b0, rv);
    run_job(2, 7, 1'b1, 0, 0, -1, 1'b0, 1'b0, rv);
    run_job(9, 3, 1'b1, 0, 2, -1, 1'b0, 1'b0, rv);
    run_job(2, 7, 1'b1, 0, 0, -3, 1'b0, 1'b0, rv);
    run_job(2, 7, 1'b1, 0, 0, -1, 1'b0, 1'b0, rv);
    start_with_abort();
    idle(3, 1'b1);

    for (int j = 0; j < 40; j++) begin
      n = ($urandom_range(9) == 0) ? int'($urandom_range(7)) : int'($urandom_range(N, 1));
      t = ($urandom_range(9) == 0) ? int'($urandom_range(12)) : int'($urandom_range(T, 1));
      run_job(n, t, 1'($urandom_range(1)), int'($urandom_range(50)), int'($urandom_range(5)),
              ($urandom_range(4) == 0) ? -2 : -1, 1'b0, 1'($urandom_range(1)), rv);
      idle(int'($urandom_range(2)), 1'($urandom_range(3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
